// File: rtl/pipe_control_unit.sv
// Pipelined control unit for the 5-stage RV32 core: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control registers, load-use hazard detection, branch flush, global freeze and stall counter.
module pipe_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter int HAZARD_EN  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  flush_ex,
  input  logic                  freeze,
  output logic                  ex_alusrc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic                  ex_memread,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  illegal_id,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic               d_alusrc, d_memtoreg, d_regwrite, d_memread, d_memwrite, d_branch, d_jump;
  logic [ALUOP_W-1:0] d_aluop;
  logic               use_rs1, use_rs2;
  logic               load_use_stall;

  logic               ex_memtoreg, ex_regwrite, ex_memwrite;
  logic               mem_regwrite, mem_memtoreg;

  always_comb begin
    d_alusrc   = 1'b0;
    d_memtoreg = 1'b0;
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_branch   = 1'b0;
    d_jump     = 1'b0;
    d_aluop    = '0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    illegal_id = 1'b0;
    case (opcode_id)
      OP_R:    begin d_regwrite = 1'b1; d_aluop = ALUOP_W'(2'b10); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_I:    begin d_alusrc = 1'b1; d_regwrite = 1'b1; use_rs1 = 1'b1; end
      OP_LW:   begin
        d_alusrc = 1'b1; d_memtoreg = 1'b1; d_regwrite = 1'b1; d_memread = 1'b1; use_rs1 = 1'b1;
      end
      OP_SW:   begin d_alusrc = 1'b1; d_memwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BEQ:  begin d_branch = 1'b1; d_aluop = ALUOP_W'(2'b01); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL:  begin d_regwrite = 1'b1; d_jump = 1'b1; end
      OP_JALR: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_jump = 1'b1; use_rs1 = 1'b1; end
      OP_LUI:  begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = ALUOP_W'(2'b11); end
      default: illegal_id = 1'b1;
    endcase
  end

  // x0 is never a real producer, so a pending load to it cannot stall.
  always_comb begin
    load_use_stall = (HAZARD_EN != 0) && ex_memread && (ex_rd != '0) &&
                     ((use_rs1 && (rs1_id == ex_rd)) || (use_rs2 && (rs2_id == ex_rd)));
  end

  assign pc_write   = ~freeze & ~(load_use_stall & ~flush_ex);
  assign ifid_write = pc_write;
  assign ifid_flush = flush_ex & ~freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_alusrc    <= 1'b0;
      ex_memtoreg  <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_aluop     <= '0;
      ex_rd        <= '0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_rd       <= '0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_rd        <= '0;
      stall_count  <= '0;
    end else if (!freeze) begin
      // Flush and stall both insert a bubble into EX; older stages always advance.
      if (flush_ex || load_use_stall) begin
        ex_alusrc   <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_branch   <= 1'b0;
        ex_jump     <= 1'b0;
        ex_aluop    <= '0;
        ex_rd       <= '0;
      end else begin
        ex_alusrc   <= d_alusrc;
        ex_memtoreg <= d_memtoreg;
        ex_regwrite <= d_regwrite;
        ex_memread  <= d_memread;
        ex_memwrite <= d_memwrite;
        ex_branch   <= d_branch;
        ex_jump     <= d_jump;
        ex_aluop    <= d_aluop;
        ex_rd       <= illegal_id ? '0 : rd_id;
      end
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_regwrite <= ex_regwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_rd       <= ex_rd;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      wb_rd        <= mem_rd;
      if (!flush_ex && load_use_stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: decode table, pipeline latency, load-use hazards,
// flush/freeze priority, illegal opcodes and stall counter saturation (CNT_W=2).
module tb_pipe_control_unit;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode_id = '0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
  logic       flush_ex = 1'b0, freeze = 1'b0;
  logic       ex_alusrc, ex_branch, ex_jump, ex_memread;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
  logic       pc_write, ifid_write, ifid_flush, illegal_id;
  logic [1:0] stall_count;

  int errors = 0;
  int checks = 0;

  pipe_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .HAZARD_EN(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .flush_ex(flush_ex), .freeze(freeze), .ex_alusrc(ex_alusrc),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_aluop(ex_aluop), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .illegal_id(illegal_id),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Every stage output packed together: {ex(11), mem(7), wb(7)}.
  function automatic logic [24:0] stages();
    return {ex_alusrc, ex_branch, ex_jump, ex_memread, ex_aluop, ex_rd,
            mem_memread, mem_memwrite, mem_rd, wb_regwrite, wb_memtoreg, wb_rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd);
    opcode_id = op;
    rs1_id    = r1;
    rs2_id    = r2;
    rd_id     = rd;
    #1;
  endtask

  task automatic do_reset();
    flush_ex = 1'b0;
    freeze   = 1'b0;
    drive(OP_BAD, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(OP_R, 5'd1, 5'd2, 5'd3);
    checks++; if (stages() !== 25'd0) begin
      errors++; $display("FAIL reset_stages got=%h exp=0", stages()); end
    checks++; if ({pc_write, ifid_write, ifid_flush, illegal_id, stall_count} !== 6'b110000) begin
      errors++; $display("FAIL reset_comb got=%b exp=110000",
                         {pc_write, ifid_write, ifid_flush, illegal_id, stall_count}); end
    tick();
    checks++; if (stages() !== 25'd0) begin
      errors++; $display("FAIL reset_hold got=%h exp=0", stages()); end
    rst_n = 1'b1;
    tick();
    checks++; if ({ex_aluop, ex_rd, ex_alusrc} !== {2'b10, 5'd3, 1'b0}) begin
      errors++; $display("FAIL reset_first_ex got=%b exp=10_00011_0", {ex_aluop, ex_rd, ex_alusrc}); end
    drive(OP_BAD, 5'd0, 5'd0, 5'd0);
    tick();
    checks++; if ({mem_rd, ex_aluop, ex_rd} !== {5'd3, 2'b00, 5'd0}) begin
      errors++; $display("FAIL reset_mem got=%b exp=00011_00_00000", {mem_rd, ex_aluop, ex_rd}); end
    tick();
    checks++; if ({wb_regwrite, wb_memtoreg, wb_rd} !== {2'b10, 5'd3}) begin
      errors++; $display("FAIL reset_wb got=%b exp=10_00011", {wb_regwrite, wb_memtoreg, wb_rd}); end
  endtask

  task automatic test_decode();
    logic [6:0] ops    [8];
    logic [5:0] exp_ex [8];  // {alusrc, branch, jump, memread, aluop}
    logic       exp_mw [8];
    logic [1:0] exp_wb [8];  // {regwrite, memtoreg}
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI};
    exp_ex = '{6'b0000_10, 6'b1000_00, 6'b1001_00, 6'b1000_00,
               6'b0100_01, 6'b0010_00, 6'b1010_00, 6'b1000_11};
    exp_mw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_wb = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(ops[i], 5'd0, 5'd0, 5'(i + 1));
      else drive(OP_BAD, 5'd0, 5'd0, 5'd0);
      checks++; if (illegal_id !== (i >= 8)) begin
        errors++; $display("FAIL decode_illegal[%0d] got=%b", i, illegal_id); end
      tick();
      if (i < 8) begin
        checks++;
        if ({ex_alusrc, ex_branch, ex_jump, ex_memread, ex_aluop, ex_rd} !== {exp_ex[i], 5'(i + 1)}) begin
          errors++; $display("FAIL decode_ex[%0d] got=%b exp=%b", i,
            {ex_alusrc, ex_branch, ex_jump, ex_memread, ex_aluop, ex_rd}, {exp_ex[i], 5'(i + 1)}); end
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if ({mem_memwrite, mem_memread, mem_rd} !== {exp_mw[i-1], ops[i-1] == OP_LW, 5'(i)}) begin
          errors++; $display("FAIL decode_mem[%0d] got=%b exp=%b", i - 1,
            {mem_memwrite, mem_memread, mem_rd}, {exp_mw[i-1], ops[i-1] == OP_LW, 5'(i)}); end
      end
      if (i >= 2) begin
        checks++;
        if ({wb_regwrite, wb_memtoreg, wb_rd} !== {exp_wb[i-2], 5'(i - 1)}) begin
          errors++; $display("FAIL decode_wb[%0d] got=%b exp=%b", i - 2,
            {wb_regwrite, wb_memtoreg, wb_rd}, {exp_wb[i-2], 5'(i - 1)}); end
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    drive(OP_R, 5'd2, 5'd5, 5'd6);
    checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin
      errors++; $display("FAIL lu_stall_comb got=%b exp=000", {pc_write, ifid_write, ifid_flush}); end
    tick();
    checks++; if ({ex_memread, ex_aluop, ex_rd, mem_memread, mem_rd, stall_count} !== {1'b0, 2'b00, 5'd0, 1'b1, 5'd5, 2'd1}) begin
      errors++; $display("FAIL lu_bubble got=%b exp=0_00_00000_1_00101_01",
        {ex_memread, ex_aluop, ex_rd, mem_memread, mem_rd, stall_count}); end
    checks++; if (pc_write !== 1'b1) begin
      errors++; $display("FAIL lu_release got=%b exp=1", pc_write); end
    tick();
    checks++; if ({ex_aluop, ex_rd, mem_rd, wb_regwrite, wb_memtoreg, wb_rd, stall_count} !== {2'b10, 5'd6, 5'd0, 2'b11, 5'd5, 2'd1}) begin
      errors++; $display("FAIL lu_resume got=%b exp=10_00110_00000_11_00101_01",
        {ex_aluop, ex_rd, mem_rd, wb_regwrite, wb_memtoreg, wb_rd, stall_count}); end
  endtask

  task automatic test_exemptions();
    do_reset();
    drive(OP_LW, 5'd1, 5'd0, 5'd0);
    tick();
    drive(OP_R, 5'd0, 5'd3, 5'd4);
    checks++; if (pc_write !== 1'b1) begin
      errors++; $display("FAIL ex_x0_nostall got=%b exp=1", pc_write); end
    tick();
    checks++; if ({ex_aluop, ex_rd} !== {2'b10, 5'd4}) begin
      errors++; $display("FAIL ex_x0_flow got=%b exp=10_00100", {ex_aluop, ex_rd}); end
    drive(OP_LW, 5'd1, 5'd0, 5'd7);
    tick();
    drive(OP_LUI, 5'd7, 5'd7, 5'd8);
    checks++; if (pc_write !== 1'b1) begin
      errors++; $display("FAIL ex_lui_nostall got=%b exp=1", pc_write); end
    tick();
    checks++; if ({ex_alusrc, ex_aluop, ex_rd, stall_count} !== {1'b1, 2'b11, 5'd8, 2'd0}) begin
      errors++; $display("FAIL ex_lui_flow got=%b exp=1_11_01000_00", {ex_alusrc, ex_aluop, ex_rd, stall_count}); end
    drive(OP_LW, 5'd1, 5'd0, 5'd7);
    tick();
    drive(OP_SW, 5'd0, 5'd7, 5'd0);
    checks++; if (pc_write !== 1'b0) begin
      errors++; $display("FAIL ex_sw_rs2_stall got=%b exp=0", pc_write); end
    drive(OP_JAL, 5'd7, 5'd7, 5'd1);
    checks++; if (pc_write !== 1'b1) begin
      errors++; $display("FAIL ex_jal_nostall got=%b exp=1", pc_write); end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    drive(OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    flush_ex = 1'b1;
    drive(OP_R, 5'd5, 5'd0, 5'd6);
    checks++; if ({ifid_flush, pc_write, ifid_write} !== 3'b111) begin
      errors++; $display("FAIL fl_comb got=%b exp=111", {ifid_flush, pc_write, ifid_write}); end
    tick();
    flush_ex = 1'b0;
    checks++; if ({ex_memread, ex_aluop, ex_rd, mem_memread, mem_rd, stall_count} !== {1'b0, 2'b00, 5'd0, 1'b1, 5'd5, 2'd0}) begin
      errors++; $display("FAIL fl_bubble got=%b exp=0_00_00000_1_00101_00",
        {ex_memread, ex_aluop, ex_rd, mem_memread, mem_rd, stall_count}); end
  endtask

  task automatic test_freeze();
    logic [24:0] snap;
    do_reset();
    drive(OP_I, 5'd0, 5'd0, 5'd1);
    tick();
    drive(OP_R, 5'd0, 5'd0, 5'd2);
    tick();
    drive(OP_LW, 5'd0, 5'd0, 5'd3);
    tick();
    snap = {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd3, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd1};
    freeze   = 1'b1;
    flush_ex = 1'b1;
    drive(OP_BEQ, 5'd9, 5'd10, 5'd0);
    checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin
      errors++; $display("FAIL fz_comb got=%b exp=000", {pc_write, ifid_write, ifid_flush}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (stages() !== snap) begin
        errors++; $display("FAIL fz_hold[%0d] got=%h exp=%h", c, stages(), snap); end
    end
    flush_ex = 1'b0;
    freeze   = 1'b0;
    #1;
    tick();
    checks++; if ({ex_branch, ex_aluop, mem_memread, mem_rd, wb_regwrite, wb_rd} !== {1'b1, 2'b01, 1'b1, 5'd3, 1'b1, 5'd2}) begin
      errors++; $display("FAIL fz_resume got=%b exp=1_01_1_00011_1_00010",
        {ex_branch, ex_aluop, mem_memread, mem_rd, wb_regwrite, wb_rd}); end
  endtask

  task automatic test_illegal_and_saturation();
    do_reset();
    drive(OP_JAL, 5'd0, 5'd0, 5'd4);
    tick();
    drive(OP_BAD, 5'd0, 5'd0, 5'd9);
    checks++; if (illegal_id !== 1'b1) begin
      errors++; $display("FAIL il_flag got=%b exp=1", illegal_id); end
    tick();
    checks++; if ({ex_alusrc, ex_branch, ex_jump, ex_memread, ex_aluop, ex_rd} !== 11'd0) begin
      errors++; $display("FAIL il_ex_bubble got=%b exp=0",
        {ex_alusrc, ex_branch, ex_jump, ex_memread, ex_aluop, ex_rd}); end
    drive(OP_JALR, 5'd0, 5'd0, 5'd8);
    checks++; if (illegal_id !== 1'b0) begin
      errors++; $display("FAIL il_clear got=%b exp=0", illegal_id); end
    tick();
    checks++; if ({mem_memread, mem_memwrite, mem_rd, ex_jump, ex_alusrc} !== {7'd0, 2'b11}) begin
      errors++; $display("FAIL il_mem_bubble got=%b exp=0000000_11",
        {mem_memread, mem_memwrite, mem_rd, ex_jump, ex_alusrc}); end
    tick();
    checks++; if ({wb_regwrite, wb_memtoreg, wb_rd, mem_rd} !== {7'd0, 5'd8}) begin
      errors++; $display("FAIL il_wb_bubble got=%b exp=0000000_01000",
        {wb_regwrite, wb_memtoreg, wb_rd, mem_rd}); end
    for (int s = 1; s <= 5; s++) begin
      drive(OP_LW, 5'd0, 5'd0, 5'd5);
      tick();
      drive(OP_R, 5'd5, 5'd0, 5'd6);
      tick();
      if (s == 3 || s == 5) begin
        checks++; if (stall_count !== 2'd3) begin
          errors++; $display("FAIL sat_count[%0d] got=%0d exp=3", s, stall_count); end
      end
    end
    drive(OP_LW, 5'd0, 5'd0, 5'd5);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({stall_count, stages()} !== 27'd0) begin
      errors++; $display("FAIL async_reset got=%h exp=0", {stall_count, stages()}); end
    tick();
    rst_n = 1'b1;
    drive(OP_R, 5'd5, 5'd0, 5'd6);
    checks++; if (pc_write !== 1'b1) begin
      errors++; $display("FAIL post_reset_nostall got=%b exp=1", pc_write); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_exemptions();
    test_flush_vs_stall();
    test_freeze();
    test_illegal_and_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
